systolic_feeder: RTL and testbench
==================================

Name: systolic_feeder

Overview:
Upstream control/feed stage for the 2x2 (generalisable NxN) output-stationary systolic_array.
- Latches operand matrices A and B on a start request.
- Clears the array accumulators.
- Streams A rows and B columns into the array with the diagonal skew it requires.
- Waits for the pipeline to drain, captures the array's C outputs and pulses done.
- Sits between the host/register interface and systolic_array.

Parameters:
N, 2, array dimension (rows = cols = inner-product length)
DATA_W, 8, operand element width
ACC_W, 16, accumulator/result element width
C_LAT, 2, cycles from the last FEED beat until c_in holds final results

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  request; accepted only in IDLE
a_mat  in  N*N*DATA_W  A, element [i][k] at bits ((i*N+k)*DATA_W)+:DATA_W
b_mat  in  N*N*DATA_W  B, element [k][j] at bits ((k*N+j)*DATA_W)+:DATA_W
c_in  in  N*N*ACC_W  array results c11..cNN, same row-major packing
a_out  out  N*DATA_W  row feeds a1..aN to the array (row i at i*DATA_W)
b_out  out  N*DATA_W  column feeds b1..bN to the array
array_clr  out  1  drives array rst, clearing accumulators
c_out  out  N*N*ACC_W  captured result matrix
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse when c_out is valid

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, counter=0, a_out=0, b_out=0, array_clr=0, c_out=0, busy=0, done=0. Latched operands cleared.
- All outputs are registered.
- FSM: IDLE -> CLEAR -> FEED -> DRAIN -> DONE -> IDLE.
- IDLE: a_out/b_out=0. When start=1, latch a_mat/b_mat and go to CLEAR.
- CLEAR: exactly 1 cycle; array_clr=1 and busy=1 during this cycle. Then go to FEED with t=0.
- FEED, beat t=0..2N-2 (2N-1 cycles):
  - row i: a_out[i] = A[i][t-i] when 0<=t-i<N, else 0
  - column j: b_out[j] = B[t-j][j] when 0<=t-j<N, else 0
  - Values are present on the ports throughout beat t.
- DRAIN: C_LAT cycles, a_out=b_out=0. On the clock edge that ends the last DRAIN cycle, c_out<=c_in.
- DONE: 1 cycle; done=1 and busy=1. The next state is IDLE.
- c_out holds its value until the next capture or reset.
- Total latency: start accepted at edge E, then done is high in cycle E+1+1+(2N-1)+C_LAT. For N=2, C_LAT=2 that is 7 cycles after E.
- start while busy (any non-IDLE state, including DONE) is ignored. There is no queuing, and the latched operands are not disturbed.
- a_mat/b_mat changes after acceptance have no effect on the current operation.
- Reset mid-operation aborts immediately to reset values. A partial result is never captured and done never pulses.
- start held high continuously: a new operation begins on each return to IDLE (one idle cycle between operations).
- No arithmetic is performed here; widths pass through unchanged, and c_out is an unmodified copy of c_in.

Decomposition:
- Package systolic_pkg:
  - default constants N, DATA_W, ACC_W
  - feeder state enum (IDLE, CLEAR, FEED, DRAIN, DONE)
  - a helper function giving the packed element offset for [r][c]
- One natural sub-module: systolic_skew_sel. It is combinational: given beat t and the latched matrices, it produces the skewed a_out/b_out next values. It is instantiated once and registered in the feeder.
- The FSM and counter stay in systolic_feeder.

Test Plan:
- Nominal run, A=[1 2;3 4], B=[5 6;7 8], start pulse, feeder connected to systolic_array. Required response:
  - beats 0..2: a_out row1 = 1,2,0; row2 = 0,3,4; col1 b = 5,7,0; col2 b = 0,6,8
  - done 7 cycles after acceptance
  - c_out = [19 22; 43 50]
- CLEAR check: array_clr high exactly 1 cycle, immediately after acceptance. Preload the array with garbage from a prior run, then expect results as above (no carry-over).
- Start while busy: pulse start during FEED and again during DONE, with different a_mat values. Required: no restart, result unchanged, busy continuous, a single done pulse.
- Operand change after accept: change a_mat to all 9s during FEED. Required: c_out still [19 22; 43 50].
- Reset mid-operation: assert rst during DRAIN. Required: all outputs 0 immediately (asynchronous), no done, and c_out stays 0. A following start gives the correct result.
- Back-to-back: start held high across two operations with B=identity. Required: c_out=A after the first done. A second done follows 8 cycles later (one IDLE cycle plus 7).

Source files
------------

// File: rtl/systolic_pkg.sv
// systolic_pkg: shared constants, feeder state encoding and packed-matrix offset helper.
//   DEF_*        default array geometry and widths
//   feeder_state_t  IDLE -> CLEAR -> FEED -> DRAIN -> DONE
//   elem_off     bit offset of element [r][c] in a row-major packed n x n matrix of w-bit elements
package systolic_pkg;
    localparam int DEF_N      = 2;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ACC_W  = 16;
    localparam int DEF_C_LAT  = 2;

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} feeder_state_t;

    function automatic int elem_off(input int r, input int c, input int n, input int w);
        return (r * n + c) * w;
    endfunction
endpackage

// File: rtl/systolic_skew_sel.sv
// systolic_skew_sel: combinational diagonal-skew selector for the systolic feed ports.
//   t      beat index to select for
//   a_mat  latched A, row-major packed
//   b_mat  latched B, row-major packed
//   a_sel  row feeds: row i carries A[i][t-i] when in range, else 0
//   b_sel  column feeds: column j carries B[t-j][j] when in range, else 0
module systolic_skew_sel
    import systolic_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = 3
) (
    input  logic [CNT_W-1:0]        t,
    input  logic [N*N*DATA_W-1:0]   a_mat,
    input  logic [N*N*DATA_W-1:0]   b_mat,
    output logic [N*DATA_W-1:0]     a_sel,
    output logic [N*DATA_W-1:0]     b_sel
);
    // Row i and column i share the same skew, so one index pair serves both.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                if (int'(t) == i + k) begin
                    a_sel[i*DATA_W +: DATA_W] = a_mat[elem_off(i, k, N, DATA_W) +: DATA_W];
                    b_sel[i*DATA_W +: DATA_W] = b_mat[elem_off(k, i, N, DATA_W) +: DATA_W];
                end
            end
        end
    end
endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: latches A/B, clears the array, streams skewed operands, drains and captures C.
//   clk, rst   clock and asynchronous active-high reset
//   start      operation request, honoured only in IDLE
//   a_mat      A operand, b_mat B operand (row-major packed)
//   c_in       result matrix from the array
//   a_out      row feeds, b_out column feeds
//   array_clr  accumulator clear for the array
//   c_out      captured result, busy while not IDLE, done one-cycle completion pulse
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int C_LAT  = DEF_C_LAT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [N*N*DATA_W-1:0]   a_mat,
    input  logic [N*N*DATA_W-1:0]   b_mat,
    input  logic [N*N*ACC_W-1:0]    c_in,
    output logic [N*DATA_W-1:0]     a_out,
    output logic [N*DATA_W-1:0]     b_out,
    output logic                    array_clr,
    output logic [N*N*ACC_W-1:0]    c_out,
    output logic                    busy,
    output logic                    done
);
    localparam int CNT_W = $clog2(2 * N + C_LAT);
    localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(2 * N - 2);
    localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(C_LAT - 1);

    feeder_state_t          state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [N*N*DATA_W-1:0]  a_lat_q, a_lat_d, b_lat_q, b_lat_d;
    logic [N*DATA_W-1:0]    a_out_q, a_out_d, b_out_q, b_out_d, a_sel, b_sel;
    logic [N*N*ACC_W-1:0]   c_out_q, c_out_d;
    logic                   array_clr_q, array_clr_d, busy_q, busy_d, done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_lat_d = a_lat_q;
        b_lat_d = b_lat_q;
        c_out_d = c_out_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = CLEAR;
                a_lat_d = a_mat;
                b_lat_d = b_mat;
            end
            CLEAR: begin
                state_d = FEED;
                cnt_d   = '0;
            end
            FEED: if (cnt_q == LAST_BEAT) begin
                state_d = DRAIN;
                cnt_d   = '0;
            end else cnt_d = cnt_q + 1'b1;
            DRAIN: if (cnt_q == LAST_DRAIN) begin
                state_d = DONE;
                cnt_d   = '0;
                c_out_d = c_in;
            end else cnt_d = cnt_q + 1'b1;
            default: state_d = IDLE;
        endcase
        // Outputs are registered, so they are derived from the state being entered.
        array_clr_d = state_d == CLEAR;
        busy_d      = state_d != IDLE;
        done_d      = state_d == DONE;
    end

    // Select the beat that will be on the ports during the next cycle.
    systolic_skew_sel #(.N(N), .DATA_W(DATA_W), .CNT_W(CNT_W)) u_skew (
        .t     (cnt_d),
        .a_mat (a_lat_q),
        .b_mat (b_lat_q),
        .a_sel (a_sel),
        .b_sel (b_sel)
    );

    assign a_out_d = state_d == FEED ? a_sel : '0;
    assign b_out_d = state_d == FEED ? b_sel : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_lat_q     <= '0;
            b_lat_q     <= '0;
            a_out_q     <= '0;
            b_out_q     <= '0;
            c_out_q     <= '0;
            array_clr_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_lat_q     <= a_lat_d;
            b_lat_q     <= b_lat_d;
            a_out_q     <= a_out_d;
            b_out_q     <= b_out_d;
            c_out_q     <= c_out_d;
            array_clr_q <= array_clr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign a_out     = a_out_q;
    assign b_out     = b_out_q;
    assign c_out     = c_out_q;
    assign array_clr = array_clr_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: randomized self-checking bench for systolic_feeder driving a behavioural systolic array.
module tb_systolic_feeder;
    localparam int N  = 2;
    localparam int DW = 8;
    localparam int AW = 16;
    localparam int CL = 2;
    localparam int MW = N * N * DW;
    localparam int CW = N * N * AW;
    localparam int VW = N * DW;
    localparam int W  = 2 * N + CL + 1;
    localparam logic [MW-1:0] A_NOM = {8'd4, 8'd3, 8'd2, 8'd1};
    localparam logic [MW-1:0] B_NOM = {8'd8, 8'd7, 8'd6, 8'd5};
    localparam logic [CW-1:0] C_NOM = {16'd50, 16'd43, 16'd22, 16'd19};
    localparam logic [31:0] CLR_EXP  = 32'd1 << 1;
    localparam logic [31:0] DONE_EXP = 32'd1 << W;
    localparam logic [31:0] BUSY_EXP = ((32'd1 << (W + 1)) - 32'd1) & ~32'd1;

    logic clk = 1'b0, rst = 1'b0, start = 1'b0, preload = 1'b0;
    logic [MW-1:0] a_mat = '0, b_mat = '0;
    logic [CW-1:0] c_in, c_out;
    logic [VW-1:0] a_out, b_out;
    logic array_clr, busy, done;
    int checks = 0, failures = 0;

    logic [DW-1:0] ah[N][N], bv[N][N];
    logic [AW-1:0] acc[N][N];
    logic [31:0] obs_clr, obs_busy, obs_done;
    logic [VW-1:0] obs_a[2*N-1], obs_b[2*N-1];
    logic [CW-1:0] obs_cap;

    always #5 clk = ~clk;

    systolic_feeder #(.N(N), .DATA_W(DW), .ACC_W(AW), .C_LAT(CL)) dut (
        .clk(clk), .rst(rst), .start(start), .a_mat(a_mat), .b_mat(b_mat), .c_in(c_in),
        .a_out(a_out), .b_out(b_out), .array_clr(array_clr), .c_out(c_out), .busy(busy), .done(done)
    );

    // Output-stationary array: A moves right, B moves down, each PE accumulates a*b.
    function automatic logic [DW-1:0] a_in(input int i, input int j);
        return j == 0 ? a_out[i*DW +: DW] : ah[i][j > 0 ? j - 1 : 0];
    endfunction

    function automatic logic [DW-1:0] b_in(input int i, input int j);
        return i == 0 ? b_out[j*DW +: DW] : bv[i > 0 ? i - 1 : 0][j];
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (array_clr) begin
                    acc[i][j] <= '0;
                    ah[i][j]  <= '0;
                    bv[i][j]  <= '0;
                end else if (preload) begin
                    acc[i][j] <= AW'($urandom);
                end else begin
                    ah[i][j]  <= a_in(i, j);
                    bv[i][j]  <= b_in(i, j);
                    acc[i][j] <= acc[i][j] + AW'(a_in(i, j)) * AW'(b_in(i, j));
                end
            end
        end
    end

    always_comb begin
        c_in = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                c_in[(i*N+j)*AW +: AW] = acc[i][j];
    end

    function automatic logic [CW-1:0] matmul(input logic [MW-1:0] a, input logic [MW-1:0] b);
        logic [CW-1:0] r;
        logic [AW-1:0] s;
        r = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                s = '0;
                for (int k = 0; k < N; k++)
                    s = s + AW'(a[(i*N+k)*DW +: DW]) * AW'(b[(k*N+j)*DW +: DW]);
                r[(i*N+j)*AW +: AW] = s;
            end
        end
        return r;
    endfunction

    function automatic logic [VW-1:0] feed_a(input logic [MW-1:0] a, input int t);
        logic [VW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++)
            if (t - i >= 0 && t - i < N) r[i*DW +: DW] = a[(i*N+t-i)*DW +: DW];
        return r;
    endfunction

    function automatic logic [VW-1:0] feed_b(input logic [MW-1:0] b, input int t);
        logic [VW-1:0] r;
        r = '0;
        for (int j = 0; j < N; j++)
            if (t - j >= 0 && t - j < N) r[j*DW +: DW] = b[((t-j)*N+j)*DW +: DW];
        return r;
    endfunction

    function automatic logic [MW-1:0] rand_mat();
        logic [MW-1:0] r;
        for (int e = 0; e < N * N; e++) r[e*DW +: DW] = DW'($urandom);
        return r;
    endfunction

    task automatic launch(input logic [MW-1:0] a, input logic [MW-1:0] b);
        @(negedge clk);
        a_mat = a;
        b_mat = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Cycle c is sampled at the falling edge after the c-th rising edge following acceptance.
    task automatic observe(input logic [31:0] smask, input logic chg, input logic [MW-1:0] alt);
        obs_clr = '0;
        obs_busy = '0;
        obs_done = '0;
        for (int c = 1; c <= W + 1; c++) begin
            @(negedge clk);
            obs_clr[c]  = array_clr;
            obs_busy[c] = busy;
            obs_done[c] = done;
            if (c >= 2 && c <= 2 * N) begin
                obs_a[c-2] = a_out;
                obs_b[c-2] = b_out;
            end
            if (c == W) obs_cap = c_out;
            start = smask[c];
            if (chg && c >= 2) a_mat = alt;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (array_clr !== 1'b0) begin failures++; $display("FAIL reset_clr: got %b want 0", array_clr); end
        checks++; if ({a_out, b_out} !== '0) begin failures++; $display("FAIL reset_feeds: got %h want 0", {a_out, b_out}); end
        checks++; if (c_out !== '0) begin failures++; $display("FAIL reset_cout: got %h want 0", c_out); end
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        checks++; if ({busy, done, array_clr, a_out, b_out} !== '0) begin failures++; $display("FAIL reset_idle: got %h want 0", {busy, done, array_clr, a_out, b_out}); end
    endtask

    task automatic test_nominal();
        launch(A_NOM, B_NOM);
        observe('0, 1'b0, '0);
        for (int t = 0; t < 2 * N - 1; t++) begin
            checks++; if (obs_a[t] !== feed_a(A_NOM, t)) begin failures++; $display("FAIL nom_a_beat%0d: got %h want %h", t, obs_a[t], feed_a(A_NOM, t)); end
            checks++; if (obs_b[t] !== feed_b(B_NOM, t)) begin failures++; $display("FAIL nom_b_beat%0d: got %h want %h", t, obs_b[t], feed_b(B_NOM, t)); end
        end
        checks++; if (obs_done !== DONE_EXP) begin failures++; $display("FAIL nom_done_timing: got %h want %h", obs_done, DONE_EXP); end
        checks++; if (obs_busy !== BUSY_EXP) begin failures++; $display("FAIL nom_busy: got %h want %h", obs_busy, BUSY_EXP); end
        checks++; if (obs_cap !== C_NOM) begin failures++; $display("FAIL nom_cout: got %h want %h", obs_cap, C_NOM); end
        checks++; if (c_out !== C_NOM) begin failures++; $display("FAIL nom_cout_hold: got %h want %h", c_out, C_NOM); end
    endtask

    task automatic test_clear();
        @(negedge clk) preload = 1'b1;
        @(negedge clk) preload = 1'b0;
        launch(A_NOM, B_NOM);
        observe('0, 1'b0, '0);
        checks++; if (obs_clr !== CLR_EXP) begin failures++; $display("FAIL clr_pulse: got %h want %h", obs_clr, CLR_EXP); end
        checks++; if (obs_cap !== C_NOM) begin failures++; $display("FAIL clr_cout: got %h want %h", obs_cap, C_NOM); end
    endtask

    task automatic test_start_while_busy();
        logic extra;
        launch(A_NOM, B_NOM);
        observe((32'd1 << 3) | (32'd1 << W), 1'b1, rand_mat());
        checks++; if (obs_busy !== BUSY_EXP) begin failures++; $display("FAIL busy_start_busy: got %h want %h", obs_busy, BUSY_EXP); end
        checks++; if (obs_done !== DONE_EXP) begin failures++; $display("FAIL busy_start_done: got %h want %h", obs_done, DONE_EXP); end
        checks++; if (obs_cap !== C_NOM) begin failures++; $display("FAIL busy_start_cout: got %h want %h", obs_cap, C_NOM); end
        extra = 1'b0;
        repeat (4) begin
            @(negedge clk);
            extra = extra | busy | done;
        end
        checks++; if (extra !== 1'b0) begin failures++; $display("FAIL busy_start_restart: got %b want 0", extra); end
    endtask

    task automatic test_operand_change();
        launch(A_NOM, B_NOM);
        observe('0, 1'b1, {N * N{8'd9}});
        checks++; if (obs_a[2*N-2] !== feed_a(A_NOM, 2 * N - 2)) begin failures++; $display("FAIL opchg_beat: got %h want %h", obs_a[2*N-2], feed_a(A_NOM, 2 * N - 2)); end
        checks++; if (obs_cap !== C_NOM) begin failures++; $display("FAIL opchg_cout: got %h want %h", obs_cap, C_NOM); end
    endtask

    task automatic test_reset_mid();
        int dones;
        launch(A_NOM, B_NOM);
        repeat (2 * N + 1) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if ({busy, done, array_clr, a_out, b_out} !== '0) begin failures++; $display("FAIL rstmid_outs: got %h want 0", {busy, done, array_clr, a_out, b_out}); end
        checks++; if (c_out !== '0) begin failures++; $display("FAIL rstmid_cout: got %h want 0", c_out); end
        @(negedge clk) rst = 1'b0;
        dones = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) dones++;
        end
        checks++; if (dones !== 0) begin failures++; $display("FAIL rstmid_done: got %0d want 0", dones); end
        checks++; if (c_out !== '0) begin failures++; $display("FAIL rstmid_cout_hold: got %h want 0", c_out); end
        launch(A_NOM, B_NOM);
        observe('0, 1'b0, '0);
        checks++; if (obs_cap !== C_NOM) begin failures++; $display("FAIL rstmid_rerun: got %h want %h", obs_cap, C_NOM); end
    endtask

    task automatic test_back_to_back();
        logic [MW-1:0] a;
        logic [CW-1:0] exp_c, cap1, cap2;
        logic [31:0] dmask;
        a = rand_mat();
        exp_c = '0;
        for (int e = 0; e < N * N; e++) exp_c[e*AW +: AW] = AW'(a[e*DW +: DW]);
        dmask = '0;
        cap1 = '0;
        cap2 = '0;
        @(negedge clk);
        a_mat = a;
        b_mat = {8'd1, 8'd0, 8'd0, 8'd1};
        start = 1'b1;
        for (int c = 1; c <= 2 * W + 2; c++) begin
            @(negedge clk);
            dmask[c] = done;
            if (c == W) cap1 = c_out;
            if (c == 2 * W + 1) begin
                cap2 = c_out;
                start = 1'b0;
            end
        end
        checks++; if (dmask !== ((32'd1 << W) | (32'd1 << (2 * W + 1)))) begin failures++; $display("FAIL b2b_done: got %h want %h", dmask, (32'd1 << W) | (32'd1 << (2 * W + 1))); end
        checks++; if (cap1 !== exp_c) begin failures++; $display("FAIL b2b_cout1: got %h want %h", cap1, exp_c); end
        checks++; if (cap2 !== exp_c) begin failures++; $display("FAIL b2b_cout2: got %h want %h", cap2, exp_c); end
    endtask

    task automatic test_random();
        logic [MW-1:0] a, b;
        for (int n = 0; n < 6; n++) begin
            a = rand_mat();
            b = rand_mat();
            launch(a, b);
            observe('0, 1'b0, '0);
            for (int t = 0; t < 2 * N - 1; t++) begin
                checks++; if (obs_a[t] !== feed_a(a, t)) begin failures++; $display("FAIL rnd%0d_a_beat%0d: got %h want %h", n, t, obs_a[t], feed_a(a, t)); end
                checks++; if (obs_b[t] !== feed_b(b, t)) begin failures++; $display("FAIL rnd%0d_b_beat%0d: got %h want %h", n, t, obs_b[t], feed_b(b, t)); end
            end
            checks++; if (obs_done !== DONE_EXP) begin failures++; $display("FAIL rnd%0d_done: got %h want %h", n, obs_done, DONE_EXP); end
            checks++; if (obs_cap !== matmul(a, b)) begin failures++; $display("FAIL rnd%0d_cout: got %h want %h", n, obs_cap, matmul(a, b)); end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_clear();
        test_start_while_busy();
        test_operand_change();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
